// File: rtl/race_pkg.sv
// Shared types and defaults for the multi-lane race position tracker.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package race_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_RACING    = 2'd2,
        ST_DONE      = 2'd3
    } race_state_t;

    localparam int DEF_FINISH_DIST     = 4020;
    localparam int DEF_COUNTDOWN_TICKS = 30;
    localparam int DEF_TIME_LIMIT      = 1200;

    // Index of the lowest set bit; 0 when no bit is set (callers gate on |v).
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

endpackage

// File: rtl/lane_accumulator.sv
// One lane: accumulates d_position, clamps at the finish line and latches the finish time.
// Latency: d_position sampled at edge k is visible in position after edge k.
// Backpressure: none; advances on every enabled tick, frozen once finished.
module lane_accumulator #(
    parameter int D_W         = 7,
    parameter int POS_W       = 16,
    parameter int TIME_W      = 12,
    parameter int FINISH_DIST = 4020
) (
    input  logic              clk10Hz,
    input  logic              clr,
    input  logic              enable,
    input  logic [D_W-1:0]    d_position,
    input  logic [TIME_W-1:0] race_time,
    output logic [POS_W-1:0]  position,
    output logic              finished,
    output logic [TIME_W-1:0] finish_time,
    output logic              finishing
);

    logic [POS_W-1:0]  r_pos;
    logic              r_fin;
    logic [TIME_W-1:0] r_ft;

    // One extra bit so an increment near the top of the range cannot wrap below the finish line.
    logic [POS_W:0]    w_sum;
    logic              w_hit;

    assign w_sum     = {1'b0, r_pos} + (POS_W+1)'(d_position);
    assign w_hit     = (w_sum >= (POS_W+1)'(FINISH_DIST));
    // High on the tick this lane crosses the line; the top uses it to pick the winner.
    assign finishing = enable & ~r_fin & w_hit;

    // Accumulate while racing; clamp to the line and latch the pre-increment race time on crossing.
    always_ff @(posedge clk10Hz) begin
        if (clr) begin
            r_pos <= '0;
            r_fin <= 1'b0;
            r_ft  <= '0;
        end else if (enable && !r_fin) begin
            if (w_hit) begin
                r_pos <= POS_W'(FINISH_DIST);
                r_fin <= 1'b1;
                r_ft  <= race_time;
            end else begin
                r_pos <= w_sum[POS_W-1:0];
            end
        end
    end

    assign position    = r_pos;
    assign finished    = r_fin;
    assign finish_time = r_ft;

endmodule

// File: rtl/race_position_tracker.sv
// Race controller: start countdown, per-lane accumulation, race timer and winner selection.
// Latency: one tick from d_position to position; state changes take effect on the next tick.
// Backpressure: none; tick-driven. Optional false-start detection under RACE_FALSE_START_EN.
module race_position_tracker
    import race_pkg::*;
#(
    parameter int N_LANES         = 2,
    parameter int D_W             = 7,
    parameter int POS_W           = 16,
    parameter int FINISH_DIST     = DEF_FINISH_DIST,
    parameter int COUNTDOWN_TICKS = DEF_COUNTDOWN_TICKS,
    parameter int TIME_W          = 12,
    parameter int TIME_LIMIT      = DEF_TIME_LIMIT
) (
    input  logic                      clk10Hz,
    input  logic                      rst,
    input  logic                      reset_status,
    input  logic                      start,
    input  logic [N_LANES*D_W-1:0]    d_position,
    output logic [N_LANES*POS_W-1:0]  position,
    output logic [N_LANES-1:0]        finished,
    output logic [N_LANES*TIME_W-1:0] finish_time,
    output logic [TIME_W-1:0]         race_time,
    output logic [2:0]                winner,
    output logic                      winner_valid,
    output logic [4:0]                countdown,
    output logic [1:0]                state
`ifdef RACE_FALSE_START_EN
    ,
    output logic [N_LANES-1:0]        false_start
`endif
);

    race_state_t       r_state;
    logic [4:0]        r_cd;
    logic [TIME_W-1:0] r_rt;
    logic [2:0]        r_winner;
    logic              r_wv;

    logic               w_clr;
    logic               w_racing;
    logic [N_LANES-1:0] w_lane_en;
    logic [N_LANES-1:0] w_fin;
    logic [N_LANES-1:0] w_fin_now;
    logic [N_LANES-1:0] w_done_mask;
    logic               w_all_done;
    logic               w_timeout;

    assign w_clr    = rst | reset_status;
    assign w_racing = (r_state == ST_RACING);

`ifdef RACE_FALSE_START_EN
    logic [N_LANES-1:0] r_fs;
    logic [N_LANES-1:0] w_nz;

    // Disqualified lanes never move and count as finished for ending the race.
    assign w_lane_en   = {N_LANES{w_racing}} & ~r_fs;
    assign w_done_mask = w_fin | r_fs;
    assign false_start = r_fs;
`else
    assign w_lane_en   = {N_LANES{w_racing}};
    assign w_done_mask = w_fin;
`endif

    assign w_all_done = &w_done_mask;
    assign w_timeout  = (r_rt == TIME_W'(TIME_LIMIT - 1));

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            lane_accumulator #(
                .D_W         (D_W),
                .POS_W       (POS_W),
                .TIME_W      (TIME_W),
                .FINISH_DIST (FINISH_DIST)
            ) u_lane (
                .clk10Hz     (clk10Hz),
                .clr         (w_clr),
                .enable      (w_lane_en[gi]),
                .d_position  (d_position[gi*D_W +: D_W]),
                .race_time   (r_rt),
                .position    (position[gi*POS_W +: POS_W]),
                .finished    (w_fin[gi]),
                .finish_time (finish_time[gi*TIME_W +: TIME_W]),
                .finishing   (w_fin_now[gi])
            );
`ifdef RACE_FALSE_START_EN
            assign w_nz[gi] = |d_position[gi*D_W +: D_W];
`endif
        end
    endgenerate

    // Race FSM with countdown, saturating timer, sticky winner and false-start latch.
    always_ff @(posedge clk10Hz) begin
        if (w_clr) begin
            r_state  <= ST_IDLE;
            r_cd     <= '0;
            r_rt     <= '0;
            r_winner <= '0;
            r_wv     <= 1'b0;
`ifdef RACE_FALSE_START_EN
            r_fs     <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_COUNTDOWN;
                        r_cd    <= 5'(COUNTDOWN_TICKS - 1);
                    end
                end
                ST_COUNTDOWN: begin
`ifdef RACE_FALSE_START_EN
                    r_fs <= r_fs | w_nz;
`endif
                    if (r_cd == 5'd0) begin
                        r_state <= ST_RACING;
                        r_rt    <= '0;
                    end else begin
                        r_cd <= r_cd - 5'd1;
                    end
                end
                ST_RACING: begin
                    if (r_rt != '1) r_rt <= r_rt + 1'b1;
                    // Only the first finishing tick decides; ties go to the lowest lane.
                    if (!r_wv && (|w_fin_now)) begin
                        r_wv     <= 1'b1;
                        r_winner <= lowest_set(8'(w_fin_now));
                    end
                    if (w_all_done || w_timeout) r_state <= ST_DONE;
                end
                default: ;
            endcase
        end
    end

    assign finished     = w_fin;
    assign race_time    = r_rt;
    assign winner       = r_winner;
    assign winner_valid = r_wv;
    assign countdown    = r_cd;
    assign state        = r_state;

endmodule

// File: doc/race_position_tracker.md
Name: race_position_tracker

Overview:
- Multi-lane successor of the single-car position accumulator.
- Tracks N_LANES cars on the 10 Hz tick: start countdown, per-lane distance accumulation with saturation at the finish line, finish flags, race timer and winner selection.
- Sits between the per-car speed/physics blocks (d_position sources) and the display/result logic.

Parameters:
- N_LANES, 2, number of cars/lanes (1..8)
- D_W, 7, width of each lane's d_position increment
- POS_W, 16, width of each lane's position accumulator
- FINISH_DIST, 4020, finish-line distance in position units; POS_W must hold it
- COUNTDOWN_TICKS, 30, countdown length in clk10Hz cycles (3 s)
- TIME_W, 12, race timer width
- TIME_LIMIT, 1200, race timeout in ticks (120 s)

Ports:
- clk10Hz  in  1  10 Hz system tick clock
- rst  in  1  synchronous active-high reset
- reset_status  in  1  synchronous race restart, same effect as rst
- start  in  1  race start request, sampled only in IDLE
- d_position  in  N_LANES*D_W  packed per-lane increments; lane i at [i*D_W +: D_W]
- position  out  N_LANES*POS_W  packed per-lane positions
- finished  out  N_LANES  per-lane finish flags (sticky)
- finish_time  out  N_LANES*TIME_W  race_time latched at each lane's finish
- race_time  out  TIME_W  ticks since RACING began
- winner  out  3  index of the first lane to finish
- winner_valid  out  1  winner is valid
- countdown  out  5  remaining countdown ticks, for the lights display
- state  out  2  FSM state: IDLE=0, COUNTDOWN=1, RACING=2, DONE=3

Behaviour:
- Reset: rst or reset_status clears all outputs to 0 and sets state to IDLE. Reset has priority over every other event.
- IDLE:
  - Positions held at 0; d_position ignored.
  - start=1 moves to COUNTDOWN and loads countdown with COUNTDOWN_TICKS-1.
- COUNTDOWN:
  - countdown decrements once per tick.
  - When countdown=0, the next tick enters RACING with race_time=0.
  - Positions stay at 0.
- RACING, per tick:
  - race_time increments; it saturates at the all-ones value.
  - For each lane that is not finished: sum = position + d_position, zero-extended to POS_W+1.
  - If sum >= FINISH_DIST: position <= FINISH_DIST, finished[i] <= 1, finish_time[i] <= race_time (the pre-increment value).
  - Otherwise position <= sum.
  - Finished lanes hold their position and finish_time.
- Winner:
  - On the first tick that sets any finished bit, winner becomes the lowest index among the newly finished lanes and winner_valid is set.
  - Both are sticky until reset.
  - A same-tick tie goes to the lowest index.
- RACING to DONE, one cycle after either condition:
  - all finished bits are set, or
  - race_time = TIME_LIMIT-1 (timeout). Unfinished lanes keep their positions; winner_valid may stay 0.
- DONE: all outputs frozen; start is ignored. Only rst or reset_status leaves DONE.
- start is ignored in every state except IDLE.
- Latency: d_position sampled at edge k appears in position after edge k (one cycle).

Optional Feature:
- Macro: RACE_FALSE_START_EN.
- Enabled:
  - Adds output false_start [N_LANES].
  - During COUNTDOWN, any lane with nonzero d_position sets its false_start bit (sticky until reset).
  - In RACING, a disqualified lane never accumulates and never finishes.
  - The all-finished check treats disqualified lanes as finished.
  - If every lane is disqualified, the FSM goes to DONE with winner_valid=0.
- Disabled: false_start port is absent; countdown-phase d_position is ignored.

Decomposition:
- Package race_pkg:
  - state encodings (ST_IDLE, ST_COUNTDOWN, ST_RACING, ST_DONE)
  - default FINISH_DIST, COUNTDOWN_TICKS and TIME_LIMIT constants
  - helper function for lowest-set-bit index
- Sub-module lane_accumulator, instantiated N_LANES times via generate:
  - inputs: enable, d_position, race_time
  - outputs: position, finished, finish_time
  - handles saturation and finish latching
- Top level holds the FSM, timer, countdown and winner logic.

Test Plan:
- Reset/idle: rst=1 then start=0 for 50 ticks -> state=0, all positions 0, winner_valid=0.
- Countdown: pulse start in IDLE -> state=1 for exactly 30 ticks, countdown 29..0; d_position=5 during this period leaves positions at 0; state=2 on tick 31.
- Finish and saturation: N_LANES=2, lane0 d=100, lane1 d=50 -> lane0 reaches FINISH_DIST (4020, clamped from 4100) with finished[0]=1, finish_time[0]=40, winner=0; lane1 finishes at race_time=80; state=3 on the following tick.
- Tie: both lanes d=67 -> both finish on the same tick with equal finish_time; winner=0.
- Timeout: lane0 d=0, lane1 d=1 -> state=3 after race_time reaches 1199; finished=00, winner_valid=0; positions frozen; start ignored in DONE.
- Mid-race reset_status: assert at race_time=15 -> next tick all outputs 0 and state=0; a new start runs a full 30-tick countdown. With RACE_FALSE_START_EN defined: lane1 d=3 during countdown -> false_start=2'b10, lane1 stays at 0, and lane0 alone completing the race ends it.
